// File: rtl/morse_pkg.sv
// Shared Morse types and constants used by the key sequencer and the LCD/decoder side.
// Element timings are expressed in Morse units.
package morse_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MARK     = 2'd1,
        SPACE    = 2'd2,
        CHAR_GAP = 2'd3
    } state_t;

    localparam int DOT_UNITS      = 1;
    localparam int DASH_UNITS     = 3;
    localparam int ELEM_GAP_UNITS = 1;
    localparam int CHAR_GAP_UNITS = 3;
    localparam int WORD_GAP_UNITS = 7;
    localparam int MAX_LEN        = 5;

    localparam int LEN_W     = 3;
    localparam int PATTERN_W = 5;
    localparam int SPEED_W   = 2;
    localparam int UNITS_W   = 3;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                   input logic [LEN_W-1:0] limit);
        return (len > limit) ? limit : len;
    endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Programmable divider: emits a one-cycle tick every (unit_last + 1) clock cycles.
// The count restarts from zero whenever clear is asserted.
module morse_unit_timer #(
    parameter int CW = 24
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          clear,
    input  logic [CW-1:0] unit_last,
    output logic          tick
);

    logic [CW-1:0] cnt;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            cnt <= '0;
        end else if (clear || cnt == unit_last) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Not gated by clear: clear is itself derived from tick through the FSM.
    assign tick = (cnt == unit_last);

endmodule

// File: rtl/morse_key_sequencer.sv
// Plays one latched Morse character on the key line with dot/dash/gap unit ratios,
// with a ready/start handshake that allows back-to-back characters.
module morse_key_sequencer #(
    parameter int UNIT_CYCLES = 12_500_000,
    parameter int MAX_LEN     = morse_pkg::MAX_LEN
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iStart,
    input  logic [2:0] iLen,
    input  logic [4:0] iPattern,
    input  logic [1:0] iSpeedSel,
    input  logic       iAbort,
    output logic       oReady,
    output logic       oBusy,
    output logic       oKey,
    output logic [2:0] oElemIdx,
    output logic       oDone
);

    import morse_pkg::*;

    localparam int CW = $clog2(UNIT_CYCLES);

    state_t                 state, state_d;
    logic [PATTERN_W-1:0]   pattern_q;
    logic [LEN_W-1:0]       len_q;
    logic                   word_gap_q;
    logic [CW-1:0]          unit_last_q;
    logic [LEN_W-1:0]       elem_q;
    logic [UNITS_W-1:0]     units_q;
    logic [UNITS_W-1:0]     target_m1;
    logic                   tick, accept, phase_end, last_elem, counters_clear;
    logic                   key_q, key_d, done_q, done_d;

    assign accept    = (state == IDLE) && iStart && !iAbort;
    assign last_elem = (elem_q == len_q - LEN_W'(1));
    assign phase_end = tick && (units_q == target_m1);
    // Counters restart on every state change and stay parked while idle.
    assign counters_clear = (state_d != state) || (state == IDLE);

    always_comb begin
        target_m1 = UNITS_W'(DOT_UNITS - 1);
        case (state)
            MARK:     target_m1 = pattern_q[elem_q] ? UNITS_W'(DASH_UNITS - 1)
                                                    : UNITS_W'(DOT_UNITS - 1);
            SPACE:    target_m1 = UNITS_W'(ELEM_GAP_UNITS - 1);
            CHAR_GAP: target_m1 = word_gap_q ? UNITS_W'(WORD_GAP_UNITS - 1)
                                             : UNITS_W'(CHAR_GAP_UNITS - 1);
            default:  target_m1 = UNITS_W'(DOT_UNITS - 1);
        endcase
    end

    morse_unit_timer #(.CW(CW)) u_timer (
        .iCLK      (iCLK),
        .iRST      (iRST),
        .clear     (counters_clear),
        .unit_last (unit_last_q),
        .tick      (tick)
    );

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state  <= IDLE;
            key_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_d;
            key_q  <= key_d;
            done_q <= done_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:     if (accept)    state_d = (iLen == '0) ? CHAR_GAP : MARK;
            MARK:     if (phase_end) state_d = last_elem ? CHAR_GAP : SPACE;
            SPACE:    if (phase_end) state_d = MARK;
            CHAR_GAP: if (phase_end) state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
        if (state != IDLE && iAbort) state_d = IDLE;
    end

    always_comb begin
        key_d  = (state_d == MARK);
        done_d = (state == CHAR_GAP) && phase_end && !iAbort;
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            pattern_q   <= '0;
            len_q       <= '0;
            word_gap_q  <= 1'b0;
            unit_last_q <= '0;
        end else if (accept) begin
            pattern_q   <= iPattern;
            len_q       <= clamp_len(iLen, LEN_W'(MAX_LEN));
            word_gap_q  <= (iLen == '0);
            unit_last_q <= CW'((UNIT_CYCLES >> iSpeedSel) - 1);
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            units_q <= '0;
            elem_q  <= '0;
        end else begin
            if (counters_clear) units_q <= '0;
            else if (tick)      units_q <= units_q + UNITS_W'(1);

            if (state_d == IDLE)                 elem_q <= '0;
            else if (state == SPACE && phase_end) elem_q <= elem_q + LEN_W'(1);
        end
    end

    assign oReady   = (state == IDLE);
    assign oBusy    = ~oReady;
    assign oKey     = key_q;
    assign oElemIdx = elem_q;
    assign oDone    = done_q;

endmodule

// File: tb/tb_morse_key_sequencer.sv
// Scoreboarded bench for morse_key_sequencer with UNIT_CYCLES=8: expected key runs are
// queued per character and a negedge monitor compares the observed runs against them.
module tb_morse_key_sequencer;

    logic       iCLK = 1'b0;
    logic       iRST = 1'b1;
    logic       iStart = 1'b0;
    logic [2:0] iLen = '0;
    logic [4:0] iPattern = '0;
    logic [1:0] iSpeedSel = '0;
    logic       iAbort = 1'b0;
    logic       oReady, oBusy, oKey, oDone;
    logic [2:0] oElemIdx;

    int n_vec = 0;
    int n_err = 0;
    logic [15:0] exp_q[$];

    // Monitor run tracking.
    logic       in_char = 1'b0;
    logic       cur_key = 1'b0;
    logic [2:0] cur_elem = '0;
    int         run_len = 0;

    morse_key_sequencer #(.UNIT_CYCLES(8), .MAX_LEN(5)) dut (
        .iCLK      (iCLK),
        .iRST      (iRST),
        .iStart    (iStart),
        .iLen      (iLen),
        .iPattern  (iPattern),
        .iSpeedSel (iSpeedSel),
        .iAbort    (iAbort),
        .oReady    (oReady),
        .oBusy     (oBusy),
        .oKey      (oKey),
        .oElemIdx  (oElemIdx),
        .oDone     (oDone)
    );

    always #5 iCLK = ~iCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard helpers ----------------
    function automatic logic [15:0] mk_run(input logic key, input logic [2:0] elem, input int len);
        return {2'd0, 1'b0, key, elem, 9'(len)};
    endfunction

    function automatic logic [15:0] mk_end(input logic done);
        return {2'd1, 13'd0, done};
    endfunction

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic sb_pop(input string name, input logic [15:0] got);
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: got %0h expected nothing (queue empty) at %0t", name, got, $time);
        end else begin
            check(name, got, exp_q.pop_front());
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge iCLK) begin
        if (iRST) begin
            in_char = 1'b0;
            run_len = 0;
        end else begin
            check("ready_busy", {14'd0, oReady, oBusy}, {14'd0, ~oBusy, oBusy});
            if (oBusy) begin
                if (in_char && oKey == cur_key && oElemIdx == cur_elem) begin
                    run_len++;
                end else begin
                    if (in_char) sb_pop("key_run", mk_run(cur_key, cur_elem, run_len));
                    in_char  = 1'b1;
                    cur_key  = oKey;
                    cur_elem = oElemIdx;
                    run_len  = 1;
                end
            end else if (in_char) begin
                sb_pop("key_run", mk_run(cur_key, cur_elem, run_len));
                sb_pop("char_end", mk_end(oDone));
                in_char = 1'b0;
            end else begin
                check("idle_done", {15'd0, oDone}, 16'd0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_ready(input int budget);
        int n = 0;
        while (!oReady && n < budget) begin
            @(posedge iCLK); #1;
            n++;
        end
        check("ready_timeout", {15'd0, oReady}, 16'd1);
    endtask

    task automatic start_char(input logic [2:0] len, input logic [4:0] pat, input logic [1:0] sel);
        wait_ready(400);
        iLen      = len;
        iPattern  = pat;
        iSpeedSel = sel;
        iStart    = 1'b1;
        @(posedge iCLK); #1;
        iStart    = 1'b0;
    endtask

    task automatic check_idle_outputs(input string name);
        check(name, {10'd0, oReady, oBusy, oKey, oElemIdx[2:0]} , {10'd0, 1'b1, 1'b0, 1'b0, 3'd0});
        check({name, "_done"}, {15'd0, oDone}, 16'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #1;
        check_idle_outputs("reset_state");
        @(posedge iCLK); #1;
        iRST = 1'b0;
        @(posedge iCLK); #1;

        // 'A' at U=8: dot, space, dash, char gap.
        exp_q.push_back(mk_run(1'b1, 3'd0, 8));
        exp_q.push_back(mk_run(1'b0, 3'd0, 8));
        exp_q.push_back(mk_run(1'b1, 3'd1, 24));
        exp_q.push_back(mk_run(1'b0, 3'd1, 24));
        exp_q.push_back(mk_end(1'b1));
        start_char(3'd2, 5'b00010, 2'd0);

        // 'E' at U=4: busy for 16 cycles.
        exp_q.push_back(mk_run(1'b1, 3'd0, 4));
        exp_q.push_back(mk_run(1'b0, 3'd0, 12));
        exp_q.push_back(mk_end(1'b1));
        start_char(3'd1, 5'b00000, 2'd1);

        // Word gap: 7 units of silence.
        exp_q.push_back(mk_run(1'b0, 3'd0, 56));
        exp_q.push_back(mk_end(1'b1));
        start_char(3'd0, 5'b10101, 2'd0);

        // Back-to-back 'E' then 'T' with iStart held; T must start right after the done cycle.
        exp_q.push_back(mk_run(1'b1, 3'd0, 8));
        exp_q.push_back(mk_run(1'b0, 3'd0, 24));
        exp_q.push_back(mk_end(1'b1));
        exp_q.push_back(mk_run(1'b1, 3'd0, 24));
        exp_q.push_back(mk_run(1'b0, 3'd0, 24));
        exp_q.push_back(mk_end(1'b1));
        wait_ready(400);
        iLen = 3'd1; iPattern = 5'b00000; iSpeedSel = 2'd0; iStart = 1'b1;
        @(posedge iCLK); #1;
        iPattern = 5'b00001;
        for (int i = 0; i < 100 && !oDone; i++) begin
            @(posedge iCLK); #1;
        end
        check("b2b_done_seen", {15'd0, oDone}, 16'd1);
        @(posedge iCLK); #1;
        iStart = 1'b0;
        check("b2b_t_mark", {14'd0, oBusy, oKey}, {14'd0, 1'b1, 1'b1});

        // Abort during the dash of 'A', 10 dash cycles in.
        exp_q.push_back(mk_run(1'b1, 3'd0, 8));
        exp_q.push_back(mk_run(1'b0, 3'd0, 8));
        exp_q.push_back(mk_run(1'b1, 3'd1, 11));
        exp_q.push_back(mk_end(1'b0));
        start_char(3'd2, 5'b00010, 2'd0);
        repeat (26) @(posedge iCLK);
        #1;
        iAbort = 1'b1;
        @(posedge iCLK); #1;
        iAbort = 1'b0;
        check_idle_outputs("abort_idle");

        // Abort wins over start while idle.
        iStart = 1'b1; iAbort = 1'b1; iLen = 3'd1;
        @(posedge iCLK); #1;
        iStart = 1'b0; iAbort = 1'b0;
        check("abort_priority", {15'd0, oReady}, 16'd1);

        // Normal character after abort.
        exp_q.push_back(mk_run(1'b1, 3'd0, 4));
        exp_q.push_back(mk_run(1'b0, 3'd0, 12));
        exp_q.push_back(mk_end(1'b1));
        start_char(3'd1, 5'b00000, 2'd1);

        // iLen=7 clamps to five dashes: 176 busy cycles.
        for (int e = 0; e < 5; e++) begin
            exp_q.push_back(mk_run(1'b1, 3'(e), 24));
            if (e < 4) exp_q.push_back(mk_run(1'b0, 3'(e), 8));
        end
        exp_q.push_back(mk_run(1'b0, 3'd4, 24));
        exp_q.push_back(mk_end(1'b1));
        start_char(3'd7, 5'b11111, 2'd0);

        // Asynchronous reset mid-MARK, checked between clock edges.
        start_char(3'd1, 5'b00001, 2'd0);
        repeat (5) @(posedge iCLK);
        #2;
        check("pre_reset_key", {15'd0, oKey}, 16'd1);
        iRST = 1'b1;
        #1;
        check_idle_outputs("async_reset");
        @(posedge iCLK); #1;
        iRST = 1'b0;
        check_idle_outputs("after_reset");

        // Recovery at U=2.
        exp_q.push_back(mk_run(1'b1, 3'd0, 2));
        exp_q.push_back(mk_run(1'b0, 3'd0, 6));
        exp_q.push_back(mk_end(1'b1));
        start_char(3'd1, 5'b00000, 2'd2);

        wait_ready(400);
        repeat (3) @(posedge iCLK);
        #1;
        check("queue_drained", 16'(exp_q.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/morse_key_sequencer.md
Name: morse_key_sequencer

Overview:
Transmit-side timing controller for the Morse unit. It accepts one character code (element count plus dot/dash pattern) and plays it out on a key line (buzzer/LED) using standard Morse unit ratios. Unit timing comes from an internal programmable unit-tick timer derived from the 50 MHz system clock. A single-character ready/start handshake lets the LCD/text front end feed characters back-to-back.

Parameters:
UNIT_CYCLES, 12_500_000, clock cycles per Morse unit at speed select 0 (0.25 s at 50 MHz); must be >= 8.
MAX_LEN, 5, maximum elements per character.

Ports:
iCLK  input  1  system clock, 50 MHz
iRST  input  1  asynchronous, active-high reset
iStart  input  1  request to play one character; sampled only while oReady=1
iLen  input  3  element count; 0 = word gap; 6-7 clamped to 5
iPattern  input  5  element i in bit i, LSB played first; 1=dash, 0=dot
iSpeedSel  input  2  unit length = UNIT_CYCLES >> iSpeedSel; sampled at accept
iAbort  input  1  cancel current character
oReady  output  1  idle and able to accept iStart
oBusy  output  1  character in progress (= ~oReady)
oKey  output  1  key line, 1 = tone/LED on
oElemIdx  output  3  index of the element currently being played or spaced
oDone  output  1  one-cycle pulse when a character completes normally

Behaviour:
- Reset: state IDLE, oReady=1, oBusy=0, oKey=0, oElemIdx=0, oDone=0, all counters 0.
- States: IDLE, MARK, SPACE, CHAR_GAP.
- Accept: in IDLE, iStart=1 and iAbort=0 at a clock edge. Latch pattern, clamped length and unit length, and clear the unit counter.
  - iLen>=1: next cycle is MARK, oKey=1, oElemIdx=0.
  - iLen=0: next cycle is CHAR_GAP with a 7-unit duration, oKey=0.
- Durations, with U = latched unit length in cycles:
  - MARK: U cycles for a dot, 3U for a dash.
  - SPACE (between elements): U cycles.
  - CHAR_GAP: 3U cycles after the last element, or 7U for a word gap.
- Transitions:
  - MARK end: if it was the last element, go to CHAR_GAP. Otherwise go to SPACE.
  - SPACE end: increment oElemIdx and go to MARK.
  - CHAR_GAP end: go to IDLE.
- Key timing: oKey is registered and equals 1 exactly during MARK cycles. There is no glitch at state boundaries.
- Completion: in the cycle CHAR_GAP's final count expires, the next state is IDLE. oDone=1 for exactly that one following cycle, coincident with oReady rising.
  - iStart in that cycle is accepted, giving back-to-back characters with no idle cycle beyond the gap.
- Latched values: iStart while busy is ignored. iPattern, iLen and iSpeedSel changes mid-character have no effect.
- Abort: iAbort=1 in any busy state.
  - Next cycle: IDLE, oKey=0, oElemIdx=0, oDone stays 0.
  - iAbort in IDLE has priority over iStart, so the start is not accepted.
- Counters:
  - Unit timer counts 0..U-1 and emits an internal one-cycle tick at U-1.
  - A 3-bit unit counter counts ticks per state against the target (1, 3 or 7).
  - Both counters clear on every state entry.
  - Counter width is $clog2(UNIT_CYCLES).
- Reset mid-character: immediate return to reset values with no oDone.

Decomposition:
- Shared package morse_pkg:
  - state enum {IDLE, MARK, SPACE, CHAR_GAP}
  - constants DOT_UNITS=1, DASH_UNITS=3, ELEM_GAP_UNITS=1, CHAR_GAP_UNITS=3, WORD_GAP_UNITS=7, MAX_LEN=5
  - code-width localparams shared with the LCD/decoder side.
- Sub-module morse_unit_timer:
  - inputs: clear, unit length
  - outputs: unit tick
  - implements the programmable divider.
- FSM, element indexing and handshake stay in the top.

Test Plan:
All scenarios use UNIT_CYCLES=8.
- 'A' (iLen=2, iPattern=5'b00010), iSpeedSel=0: oKey high 8 cycles, low 8, high 24, then low 24. oDone pulses 64 cycles after accept; oElemIdx goes 0→1.
- iSpeedSel=1 (U=4), 'E' (iLen=1, pattern 0): oKey high 4, low 12. oDone pulses at cycle 16; oBusy is 1 for exactly 16 cycles.
- Word gap: iLen=0 → oKey stays 0, oBusy for 56 cycles, then oDone.
- Back-to-back: iStart held high with 'E' then 'T' → 'T' is accepted in the oDone cycle, and 'T' mark (24 cycles) begins the next cycle.
- Abort during the dash of 'A' (10 cycles into the dash) → next cycle oKey=0, oReady=1, no oDone; a following iStart plays normally.
- Async iRST mid-MARK: all outputs reset immediately without waiting for a clock edge. iLen=7 with iPattern=5'b11111 is clamped to 5 dashes (5×24 + 4×8 + 24 = 176 cycles).
